// File: rtl/mips_ctrl_pkg.sv
// Shared decode constants and the control-bundle layout for the ID stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_ctrl_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;

    // SPECIAL2 funct, instr[5:0]
    localparam logic [5:0] FN_MUL      = 6'b000010;

    // ALU operation codes (4-bit core encoding)
    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_RTYPE   = 4'b0010;
    localparam logic [3:0] ALU_SPECIAL = 4'b0011;
    localparam logic [3:0] ALU_SLT     = 4'b0100;

    // Field order matches the decode table so table rows can be cast directly
    typedef struct packed {
        logic       reverse;
        logic       jump;
        logic [3:0] alu_op;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dest;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/id_ctrl_stage_ctrl_rom.sv
// Combinational opcode/funct decoder producing the control bundle.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module ctrl_rom
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        multicycle
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Register/immediate fields are consumed elsewhere in the pipeline
    assign unused_instr_bits = ^instr[25:6];

    // Row layout: {reverse, jump, alu_op, mem_write, reg_write, reg_dest, alu_src, mem_to_reg, branch}
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LW:       ctrl = ctrl_t'({2'b00, ALU_ADD,     6'b010110});
            OP_SW:       ctrl = ctrl_t'({2'b00, ALU_ADD,     6'b100110});
            OP_RTYPE:    ctrl = ctrl_t'({2'b00, ALU_RTYPE,   6'b011000});
            OP_SPECIAL2: ctrl = ctrl_t'({2'b00, ALU_SPECIAL, 6'b011000});
            OP_ADDI:     ctrl = ctrl_t'({2'b00, ALU_ADD,     6'b010100});
            OP_SLTI:     ctrl = ctrl_t'({2'b00, ALU_SLT,     6'b010100});
            OP_BEQ:      ctrl = ctrl_t'({2'b00, ALU_SUB,     6'b000001});
            OP_BNE:      ctrl = ctrl_t'({2'b10, ALU_SUB,     6'b000001});
            OP_J:        ctrl = ctrl_t'({2'b01, ALU_ADD,     6'b000000});
            default:     illegal = 1'b1;
        endcase
    end

    assign multicycle = (opcode == OP_SPECIAL2) && (funct == FN_MUL);

endmodule

// File: rtl/id_ctrl_stage.sv
// ID control stage: decodes instr into a registered control bundle with valid/ready, flush and MUL issue stall.
// Latency: one cycle from accept to out_valid.
// Backpressure: in_ready drops while the held bundle is unconsumed or while a MUL issue stall is counting down.
module id_ctrl_stage
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 4,
    parameter int MULDIV_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               mem_write,
    output logic               reg_write,
    output logic               reg_dest,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               branch,
    output logic               jump,
    output logic               reverse,
    output logic               illegal,
    output logic               multicycle,
    output logic               busy
);

    localparam int CNT_W = (MULDIV_LAT > 0) ? $clog2(MULDIV_LAT + 1) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    ctrl_t rom_ctrl;
    logic  rom_illegal;
    logic  rom_multi;

    ctrl_t ctrl_q;
    logic  illegal_q;
    logic  multi_q;

    logic  accept;
    logic  consume;

    ctrl_rom u_rom (
        .instr      (instr),
        .ctrl       (rom_ctrl),
        .illegal    (rom_illegal),
        .multicycle (rom_multi)
    );

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = out_valid && out_ready && !accept;
    assign busy     = (state == ST_HOLD);

    // Issue-stall state and countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: a MUL opens a stall window; leave HOLD on the cycle cnt hits 1; flush aborts
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && rom_multi && (MULDIV_LAT > 0)) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = CNT_W'(MULDIV_LAT);
                    end
                end
                ST_HOLD: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output register: load on accept, drop valid on consume or flush (bundle fields left as-is)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            multi_q   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ctrl_q    <= rom_ctrl;
            illegal_q <= rom_illegal;
            multi_q   <= rom_multi;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    assign alu_op     = ALUOP_W'(ctrl_q.alu_op);
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dest   = ctrl_q.reg_dest;
    assign alu_src    = ctrl_q.alu_src;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign reverse    = ctrl_q.reverse;
    assign illegal    = illegal_q;
    assign multicycle = multi_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage with a cycle-level reference model and literal spot checks.
// Latency: model predicts outputs one cycle after each accept.
// Backpressure: out_ready is driven low for a stretch to exercise hold behaviour.
module tb_id_ctrl_stage;

    localparam int ALUOP_W = 6;
    localparam int LAT     = 3;

    localparam logic [31:0] I_LW    = 32'h8C010004;
    localparam logic [31:0] I_SW    = 32'hAC010008;
    localparam logic [31:0] I_RTYPE = 32'h00221820;
    localparam logic [31:0] I_SP2   = 32'h70221820;
    localparam logic [31:0] I_MUL   = 32'h70221802;
    localparam logic [31:0] I_ADDI  = 32'h20210005;
    localparam logic [31:0] I_SLTI  = 32'h28210007;
    localparam logic [31:0] I_BEQ   = 32'h10220002;
    localparam logic [31:0] I_BNE   = 32'h14220003;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_BAD   = 32'hFC000000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        instr = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_write, reg_write, reg_dest, alu_src, mem_to_reg;
    logic               branch, jump, reverse, illegal, multicycle, busy;

    int tests = 0;
    int fails = 0;

    // Reference model: pending-output flag, expected bundle, cycles of issue still blocked
    bit          m_valid  = 1'b0;
    logic [13:0] m_bundle = '0;
    int          m_stall  = 0;

    id_ctrl_stage #(.ALUOP_W(ALUOP_W), .MULDIV_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dest   (reg_dest),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .branch     (branch),
        .jump       (jump),
        .reverse    (reverse),
        .illegal    (illegal),
        .multicycle (multicycle),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // {illegal, multicycle, reverse, jump, alu_op[3:0], mem_write, reg_write, reg_dest, alu_src, mem_to_reg, branch}
    function automatic logic [13:0] ref_decode(input logic [31:0] w);
        logic [11:0] row;
        logic        bad;
        bad = 1'b0;
        case (w[31:26])
            6'b100011: row = {2'b00, 4'd0, 6'b010110};
            6'b101011: row = {2'b00, 4'd0, 6'b100110};
            6'b000000: row = {2'b00, 4'd2, 6'b011000};
            6'b011100: row = {2'b00, 4'd3, 6'b011000};
            6'b001000: row = {2'b00, 4'd0, 6'b010100};
            6'b001010: row = {2'b00, 4'd4, 6'b010100};
            6'b000100: row = {2'b00, 4'd1, 6'b000001};
            6'b000101: row = {2'b10, 4'd1, 6'b000001};
            6'b000010: row = {2'b01, 4'd0, 6'b000000};
            default: begin
                row = '0;
                bad = 1'b1;
            end
        endcase
        return {bad, (w[31:26] == 6'b011100) && (w[5:0] == 6'b000010), row};
    endfunction

    function automatic logic [13:0] dut_bundle();
        return {illegal, multicycle, reverse, jump, alu_op[3:0],
                mem_write, reg_write, reg_dest, alu_src, mem_to_reg, branch};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit ready;
        if (rst) begin
            m_valid  = 1'b0;
            m_stall  = 0;
            m_bundle = '0;
        end else begin
            ready = (m_stall == 0) && (!m_valid || out_ready);
            if (flush) begin
                m_valid = 1'b0;
                m_stall = 0;
            end else if (in_valid && ready) begin
                m_valid  = 1'b1;
                m_bundle = ref_decode(instr);
                m_stall  = m_bundle[12] ? LAT : 0;
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (m_stall > 0) m_stall--;
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'((m_stall == 0) && (!m_valid || out_ready)));
        chk("busy", 32'(busy), 32'(m_stall > 0));
        if (m_valid) begin
            chk("bundle", 32'(dut_bundle()), 32'(m_bundle));
            chk("alu_op_upper", 32'(alu_op[ALUOP_W-1:4]), 32'd0);
        end
    endtask

    // One clock: model tracks the edge, then outputs are compared at the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [31:0] w);
        instr    = w;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        int blocked;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ctrls", 32'(dut_bundle()), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // LW, single issue
        out_ready = 1'b1;
        send(I_LW);
        chk("lw_out_valid", 32'(out_valid), 32'd1);
        chk("lw_reg_write", 32'(reg_write), 32'd1);
        chk("lw_alu_src", 32'(alu_src), 32'd1);
        chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("lw_alu_op", 32'(alu_op), 32'd0);
        chk("lw_illegal", 32'(illegal), 32'd0);

        // BNE then J back-to-back
        send(I_BNE);
        chk("bne_fields", 32'({reverse, branch, jump}), 32'b110);
        chk("bne_alu_op", 32'(alu_op), 32'd1);
        send(I_J);
        chk("j_bundle", 32'(dut_bundle()), 32'({2'b00, 2'b01, 4'd0, 6'd0}));

        // Remaining table rows streamed back-to-back
        send(I_SW);
        send(I_RTYPE);
        send(I_BEQ);
        send(I_SP2);
        chk("sp2_not_multicycle", 32'({multicycle, busy}), 32'd0);
        chk("sp2_alu_op", 32'(alu_op), 32'd3);
        in_valid = 1'b0;
        tick();

        // MUL followed by ADDI waiting on in_valid
        send(I_MUL);
        chk("mul_multicycle", 32'(multicycle), 32'd1);
        chk("mul_busy", 32'(busy), 32'd1);
        instr   = I_ADDI;
        blocked = 0;
        for (int i = 0; i < 10 && !in_ready; i++) begin
            blocked++;
            tick();
        end
        chk("mul_stall_cycles", 32'(blocked), 32'(LAT));
        tick();
        chk("addi_after_mul", 32'(dut_bundle()), 32'({2'b00, 2'b00, 4'd0, 6'b010100}));
        in_valid = 1'b0;
        tick();

        // SLTI held under backpressure
        out_ready = 1'b0;
        send(I_SLTI);
        in_valid = 1'b1;
        instr    = I_ADDI;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("slti_hold_alu_op", 32'(alu_op), 32'd4);
            chk("slti_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("slti_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("slti_consumed", 32'(out_valid), 32'd0);

        // Illegal opcode
        send(I_BAD);
        chk("bad_illegal", 32'(illegal), 32'd1);
        chk("bad_valid", 32'(out_valid), 32'd1);
        chk("bad_ctrls", 32'(dut_bundle()), 32'({2'b10, 12'd0}));
        in_valid = 1'b0;
        tick();

        // Flush in IDLE drops the same-cycle instruction
        flush = 1'b1;
        send(I_LW);
        chk("flush_idle_valid", 32'(out_valid), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();

        // Flush during HOLD with an instruction offered
        send(I_MUL);
        flush = 1'b1;
        send(I_ADDI);
        chk("flush_hold_state", 32'({out_valid, busy, in_ready}), 32'b001);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_dropped", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset in the middle of HOLD
        send(I_MUL);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_ctrls", 32'(dut_bundle()), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send(I_LW);
        chk("post_arst_lw", 32'(dut_bundle()), 32'({2'b00, 2'b00, 4'd0, 6'b010110}));
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
